// File: rtl/apb_spi_master_if.sv
// ============================================================================
// apb_spi_master_if : APB slave port bundle for the SPI master
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_spi_master_if;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready
  );
endinterface

`default_nettype wire

// File: rtl/apb_spi_master.sv
// ============================================================================
// apb_spi_master : APB-attached SPI master, 1..DATA_W bits MSB-first, all modes
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_spi_master #(
  parameter int DATA_W = 32,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  apb_spi_master_if.slave   apb,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              irq
);

  localparam logic [5:0] c_DATA_W      = 6'(DATA_W);
  localparam logic [5:0] c_ADDR_DATA   = 6'h00;
  localparam logic [5:0] c_ADDR_CTRL   = 6'h01;
  localparam logic [5:0] c_ADDR_STATUS = 6'h02;
  localparam logic [5:0] c_ADDR_CONFIG = 6'h03;
  localparam logic [5:0] c_ADDR_CS     = 6'h04;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_TRAIL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_tx_sh;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_sh;
  logic [5:0]          r_len;
  logic [5:0]          r_bit_cnt;
  logic                r_irq_en;
  logic                r_done;
  logic                r_irq;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_cnt;
  logic                r_cpol;
  logic                r_cpha;
  logic [NUM_CS-1:0]   r_cs;
  logic                r_sclk;
  logic                r_mosi;

  logic                w_access;
  logic                w_wr_data;
  logic                w_wr_ctrl;
  logic                w_wr_status;
  logic                w_wr_cfg;
  logic                w_wr_cs;
  logic [5:0]          w_len;
  logic                w_len_ok;
  logic                w_busy;
  logic                w_start;
  logic                w_cnt_zero;
  logic                w_lead_edge;
  logic                w_trail_edge;
  logic                w_finish;
  logic [DATA_W-1:0]   w_tx_aligned;
  logic [DATA_W-1:0]   w_rx_next;
  logic [31:0]         w_cfg_rd;
  logic [31:0]         w_cs_rd;
  logic                w_unused;

  assign w_access    = apb.psel & apb.penable & apb.pwrite;
  assign w_wr_data   = w_access & (apb.paddr[7:2] == c_ADDR_DATA);
  assign w_wr_ctrl   = w_access & (apb.paddr[7:2] == c_ADDR_CTRL);
  assign w_wr_status = w_access & (apb.paddr[7:2] == c_ADDR_STATUS);
  assign w_wr_cfg    = w_access & (apb.paddr[7:2] == c_ADDR_CONFIG);
  assign w_wr_cs     = w_access & (apb.paddr[7:2] == c_ADDR_CS);

  assign w_len       = apb.pwdata[5:0];
  assign w_len_ok    = (w_len != 6'd0) && (w_len <= c_DATA_W);
  assign w_busy      = (r_state == S_LEAD) || (r_state == S_TRAIL);
  assign w_start     = w_wr_ctrl & ~w_busy & w_len_ok;
  assign w_cnt_zero  = (r_cnt == '0);

  // Left-align the len-bit word so the next bit out is always the MSB.
  assign w_tx_aligned = r_tx << (c_DATA_W - w_len);
  assign w_rx_next    = {r_rx_sh[DATA_W-2:0], spi_miso};

  assign w_unused = &{1'b0, apb.paddr[1:0], apb.pwdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lead_edge  = 1'b0;
    w_trail_edge = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = w_start ? S_LEAD : S_IDLE;
      end
      S_LEAD: begin
        if (w_cnt_zero) begin
          w_lead_edge = 1'b1;
          w_state_nxt = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (w_cnt_zero) begin
          w_trail_edge = 1'b1;
          if (r_bit_cnt == 6'd0) begin
            w_finish    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LEAD;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx      <= '0;
      r_tx_sh   <= '0;
      r_rx      <= '0;
      r_rx_sh   <= '0;
      r_len     <= '0;
      r_bit_cnt <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_irq     <= 1'b0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_cs      <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      if (w_wr_data && !w_busy) begin
        r_tx <= apb.pwdata[DATA_W-1:0];
      end
      if (w_wr_ctrl && !w_busy) begin
        r_irq_en <= apb.pwdata[8];
        if (w_len_ok) begin
          r_len <= w_len;
        end
      end
      if (w_wr_cfg && !w_busy) begin
        r_div  <= apb.pwdata[DIV_W-1:0];
        r_cpol <= apb.pwdata[16];
        r_cpha <= apb.pwdata[17];
        r_sclk <= apb.pwdata[16];
      end
      if (w_wr_cs) begin
        r_cs <= apb.pwdata[NUM_CS-1:0];
      end

      // Completion outranks a simultaneous write-one-to-clear.
      if (w_finish) begin
        r_done <= 1'b1;
      end else if (w_start || (w_wr_status && apb.pwdata[1])) begin
        r_done <= 1'b0;
      end
      r_irq <= r_done & r_irq_en;

      if (w_start) begin
        r_cnt     <= r_div;
        r_bit_cnt <= w_len - 6'd1;
        r_rx_sh   <= '0;
        if (r_cpha) begin
          r_tx_sh <= w_tx_aligned;
          r_mosi  <= 1'b0;
        end else begin
          r_tx_sh <= w_tx_aligned << 1;
          r_mosi  <= w_tx_aligned[DATA_W-1];
        end
      end else if (w_busy) begin
        r_cnt <= w_cnt_zero ? r_div : (r_cnt - DIV_W'(1));
        if (w_lead_edge) begin
          r_sclk <= ~r_cpol;
          if (r_cpha) begin
            r_mosi  <= r_tx_sh[DATA_W-1];
            r_tx_sh <= r_tx_sh << 1;
          end else begin
            r_rx_sh <= w_rx_next;
          end
        end
        if (w_trail_edge) begin
          r_sclk <= r_cpol;
          if (r_cpha) begin
            r_rx_sh <= w_rx_next;
          end
          if (w_finish) begin
            r_mosi <= 1'b0;
            r_rx   <= r_cpha ? w_rx_next : r_rx_sh;
          end else begin
            r_bit_cnt <= r_bit_cnt - 6'd1;
            if (!r_cpha) begin
              r_mosi  <= r_tx_sh[DATA_W-1];
              r_tx_sh <= r_tx_sh << 1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_cfg_rd              = '0;
    w_cfg_rd[DIV_W-1:0]   = r_div;
    w_cfg_rd[16]          = r_cpol;
    w_cfg_rd[17]          = r_cpha;
    w_cs_rd               = '0;
    w_cs_rd[NUM_CS-1:0]   = r_cs;
  end

  always_comb begin
    apb.prdata = '0;
    if (apb.psel && !apb.pwrite) begin
      case (apb.paddr[7:2])
        c_ADDR_DATA:   apb.prdata = 32'(r_rx);
        c_ADDR_CTRL:   apb.prdata = {23'd0, r_irq_en, 2'd0, r_len};
        c_ADDR_STATUS: apb.prdata = {30'd0, r_done, w_busy};
        c_ADDR_CONFIG: apb.prdata = w_cfg_rd;
        c_ADDR_CS:     apb.prdata = w_cs_rd;
        default:       apb.prdata = '1;
      endcase
    end
  end

  assign apb.pready = 1'b1;
  assign spi_sclk   = r_sclk;
  assign spi_mosi   = r_mosi;
  assign spi_cs_n   = ~r_cs;
  assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_apb_spi_master.sv
// ============================================================================
// tb_apb_spi_master : directed self-checking bench for apb_spi_master
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [3:0] spi_cs_n;
  logic       irq;
  logic       miso_loop;
  logic       miso_force;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  apb_spi_master_if apb ();

  apb_spi_master #(
    .DATA_W (32),
    .NUM_CS (4),
    .DIV_W  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .apb      (apb.slave),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign spi_miso = miso_loop ? spi_mosi : miso_force;

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
    apb.paddr = a; apb.pwdata = d;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = a;
    #1;
    d = apb.prdata;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // Polls STATUS combinationally each cycle while busy, logging SCLK edges and MOSI.
  task automatic monitor_xfer(input int limit, output int nbusy, output int nrise,
                              output int nfall, output logic [31:0] wr,
                              output logic [31:0] wf, output logic done_first,
                              output logic done_end);
    logic prev;
    prev = spi_sclk;
    nbusy = 0; nrise = 0; nfall = 0; wr = '0; wf = '0;
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = 8'h08;
    #1;
    done_first = apb.prdata[1];
    while (apb.prdata[0] && nbusy < limit) begin
      nbusy++;
      if (spi_sclk && !prev) begin nrise++; wr = {wr[30:0], spi_mosi}; end
      if (!spi_sclk && prev) begin nfall++; wf = {wf[30:0], spi_mosi}; end
      prev = spi_sclk;
      @(posedge clk); #1;
    end
    done_end = apb.prdata[1];
    apb.psel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    miso_loop = 1'b1; miso_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_vec++; if (spi_sclk !== 1'b0) begin $display("FAIL rst_sclk got %b want 0", spi_sclk); n_err++; end
    n_vec++; if (spi_mosi !== 1'b0) begin $display("FAIL rst_mosi got %b want 0", spi_mosi); n_err++; end
    n_vec++; if (spi_cs_n !== 4'hF) begin $display("FAIL rst_cs_n got %h want f", spi_cs_n); n_err++; end
    n_vec++; if (irq !== 1'b0) begin $display("FAIL rst_irq got %b want 0", irq); n_err++; end
    n_vec++; if (apb.pready !== 1'b1) begin $display("FAIL pready got %b want 1", apb.pready); n_err++; end
    n_vec++; if (apb.prdata !== 32'h0) begin $display("FAIL prdata_nosel got %h want 0", apb.prdata); n_err++; end
    apb_read(8'h08, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL rst_status got %h want 0", d); n_err++; end
    apb_read(8'h00, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL rst_data got %h want 0", d); n_err++; end
    apb_read(8'h04, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL rst_ctrl got %h want 0", d); n_err++; end
    apb_read(8'h0C, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL rst_config got %h want 0", d); n_err++; end
  endtask

  task automatic test_mode0();
    int nb, nr, nf; logic [31:0] wr, wf, d; logic df, de;
    miso_loop = 1'b1;
    apb_write(8'h10, 32'h1);
    apb_write(8'h0C, 32'h0);
    apb_write(8'h00, 32'hA5);
    apb_write(8'h04, 32'd8);
    monitor_xfer(100, nb, nr, nf, wr, wf, df, de);
    n_vec++; if (nb !== 16) begin $display("FAIL m0_busy got %0d want 16", nb); n_err++; end
    n_vec++; if (nr !== 8) begin $display("FAIL m0_rises got %0d want 8", nr); n_err++; end
    n_vec++; if (wr !== 32'hA5) begin $display("FAIL m0_mosi got %h want a5", wr); n_err++; end
    n_vec++; if (de !== 1'b1) begin $display("FAIL m0_done got %b want 1", de); n_err++; end
    n_vec++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
      $display("FAIL m0_idle sclk/mosi got %b%b want 00", spi_sclk, spi_mosi); n_err++; end
    n_vec++; if (spi_cs_n !== 4'b1110) begin $display("FAIL m0_cs_n got %b want 1110", spi_cs_n); n_err++; end
    apb_read(8'h00, d);
    n_vec++; if (d !== 32'h0000_00A5) begin $display("FAIL m0_rx got %h want 000000a5", d); n_err++; end
  endtask

  task automatic test_mode3();
    int nb, nr, nf; logic [31:0] wr, wf, d; logic df, de;
    miso_loop = 1'b0; miso_force = 1'b1;
    apb_write(8'h0C, 32'h0003_0002);
    n_vec++; if (spi_sclk !== 1'b1) begin $display("FAIL m3_idle_sclk got %b want 1", spi_sclk); n_err++; end
    apb_write(8'h00, 32'h1234_5678);
    apb_write(8'h04, 32'd32);
    monitor_xfer(400, nb, nr, nf, wr, wf, df, de);
    n_vec++; if (nb !== 192) begin $display("FAIL m3_busy got %0d want 192", nb); n_err++; end
    n_vec++; if (nf !== 32) begin $display("FAIL m3_falls got %0d want 32", nf); n_err++; end
    n_vec++; if (wf !== 32'h1234_5678) begin $display("FAIL m3_mosi got %h want 12345678", wf); n_err++; end
    n_vec++; if (spi_sclk !== 1'b1 || spi_mosi !== 1'b0) begin
      $display("FAIL m3_end sclk/mosi got %b%b want 10", spi_sclk, spi_mosi); n_err++; end
    apb_read(8'h00, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin $display("FAIL m3_rx got %h want ffffffff", d); n_err++; end
  endtask

  task automatic test_bad_len();
    logic [31:0] d;
    apb_write(8'h04, 32'h100);
    apb_read(8'h08, d);
    n_vec++; if (d !== 32'h2) begin $display("FAIL len0_status got %h want 2", d); n_err++; end
    apb_read(8'h04, d);
    n_vec++; if (d !== 32'h120) begin $display("FAIL len0_ctrl got %h want 120", d); n_err++; end
    apb_write(8'h04, 32'd33);
    apb_read(8'h08, d);
    n_vec++; if (d !== 32'h2) begin $display("FAIL len33_status got %h want 2", d); n_err++; end
    apb_read(8'h04, d);
    n_vec++; if (d !== 32'h020) begin $display("FAIL len33_ctrl got %h want 20", d); n_err++; end
  endtask

  task automatic test_busy_ignore();
    int nb, nr, nf, t0, t1; logic [31:0] wr, wf, d; logic df, de;
    miso_loop = 1'b1;
    apb_write(8'h0C, 32'h1);
    apb_write(8'h00, 32'h3C);
    apb_write(8'h04, 32'd8);
    t0 = cyc;
    apb_write(8'h0C, 32'h5);
    apb_write(8'h00, 32'hFF);
    monitor_xfer(100, nb, nr, nf, wr, wf, df, de);
    t1 = cyc;
    n_vec++; if (t1 - t0 !== 32) begin $display("FAIL bi_busy got %0d want 32", t1 - t0); n_err++; end
    n_vec++; if (de !== 1'b1) begin $display("FAIL bi_done got %b want 1", de); n_err++; end
    apb_read(8'h00, d);
    n_vec++; if (d !== 32'h3C) begin $display("FAIL bi_rx got %h want 3c", d); n_err++; end
    apb_read(8'h0C, d);
    n_vec++; if (d !== 32'h1) begin $display("FAIL bi_config got %h want 1", d); n_err++; end
  endtask

  task automatic test_mode1_short();
    int nb, nr, nf; logic [31:0] wr, wf, d; logic df, de;
    miso_loop = 1'b1;
    apb_write(8'h0C, 32'h0002_0003);
    apb_write(8'h00, 32'hFFFF_FF13);
    apb_write(8'h04, 32'd5);
    monitor_xfer(100, nb, nr, nf, wr, wf, df, de);
    n_vec++; if (nb !== 40) begin $display("FAIL m1_busy got %0d want 40", nb); n_err++; end
    n_vec++; if (nr !== 5) begin $display("FAIL m1_rises got %0d want 5", nr); n_err++; end
    n_vec++; if (wr !== 32'h13) begin $display("FAIL m1_mosi got %h want 13", wr); n_err++; end
    apb_read(8'h00, d);
    n_vec++; if (d !== 32'h13) begin $display("FAIL m1_rx got %h want 13", d); n_err++; end
  endtask

  task automatic test_irq();
    int nb, nr, nf; logic [31:0] wr, wf, d; logic df, de;
    miso_loop = 1'b1;
    apb_write(8'h0C, 32'h0);
    apb_write(8'h00, 32'h5A);
    apb_write(8'h04, 32'h108);
    monitor_xfer(100, nb, nr, nf, wr, wf, df, de);
    n_vec++; if (df !== 1'b0) begin $display("FAIL irq_start_done got %b want 0", df); n_err++; end
    n_vec++; if (nb !== 16) begin $display("FAIL irq_busy got %0d want 16", nb); n_err++; end
    n_vec++; if (de !== 1'b1 || irq !== 1'b0) begin
      $display("FAIL irq_lag done/irq got %b%b want 10", de, irq); n_err++; end
    @(posedge clk); #1;
    n_vec++; if (irq !== 1'b1) begin $display("FAIL irq_set got %b want 1", irq); n_err++; end
    apb_read(8'h00, d);
    n_vec++; if (d !== 32'h5A) begin $display("FAIL irq_rx got %h want 5a", d); n_err++; end
    apb_read(8'h08, d);
    n_vec++; if (d !== 32'h2) begin $display("FAIL irq_status got %h want 2", d); n_err++; end
    apb_write(8'h08, 32'h2);
    apb_read(8'h08, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL w1c_status got %h want 0", d); n_err++; end
    n_vec++; if (irq !== 1'b0) begin $display("FAIL w1c_irq got %b want 0", irq); n_err++; end
    apb_read(8'h3C, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin $display("FAIL unmapped got %h want ffffffff", d); n_err++; end
    #1;
    n_vec++; if (apb.prdata !== 32'h0) begin $display("FAIL idle_prdata got %h want 0", apb.prdata); n_err++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    miso_loop = 1'b1;
    apb_write(8'h10, 32'h3);
    apb_write(8'h0C, 32'h0001_0000);
    apb_write(8'h00, 32'hA5);
    apb_write(8'h04, 32'd8);
    repeat (8) @(posedge clk);
    #1;
    n_vec++; if (spi_cs_n !== 4'b1100) begin $display("FAIL mid_cs_n got %b want 1100", spi_cs_n); n_err++; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_vec++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
      $display("FAIL mid_rst sclk/mosi got %b%b want 00", spi_sclk, spi_mosi); n_err++; end
    n_vec++; if (spi_cs_n !== 4'hF || irq !== 1'b0) begin
      $display("FAIL mid_rst cs_n/irq got %b/%b want 1111/0", spi_cs_n, irq); n_err++; end
    apb_read(8'h08, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL mid_rst_status got %h want 0", d); n_err++; end
    apb_read(8'h00, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL mid_rst_rx got %h want 0", d); n_err++; end
    apb_read(8'h0C, d);
    n_vec++; if (d !== 32'h0) begin $display("FAIL mid_rst_config got %h want 0", d); n_err++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d miscompares so far", n_err);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_bad_len();
    test_busy_ignore();
    test_mode1_short();
    test_irq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
